// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_pkg
// Purpose : Shared AXI definitions for the read-side memory slave and any
//           future write-side slaves: burst and response encodings, the
//           latched AR beat descriptor and the read FSM state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package axi_pkg;

   // Widest byte address any slave in this family supports. Descriptors
   // carry addresses at this width and slaves mask down to their own span.
   localparam int AXI_MAX_ADDR_WIDTH = 32;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // Descriptor of the burst in flight; addr is the address of the beat
   // currently being presented, the other fields are as accepted on AR.
   typedef struct packed {
      logic [AXI_MAX_ADDR_WIDTH-1:0] addr;
      logic [7:0]                    len;
      logic [2:0]                    size;
      logic [1:0]                    burst;
   } axi_ar_desc_t;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } rd_state_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : axi_burst_addr_gen
// Purpose : Combinational AXI next-beat address computation. Given the
//           address of the current beat plus len/size/burst, produce the
//           address of the following beat, modulo 2^ADDRESS_WIDTH.
// Ports   : i_desc      - current beat descriptor (addr, len, size, burst)
//           o_next_addr - address of the next beat (upper bits zero)
// Revision: 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8
) (
   input  axi_ar_desc_t                  i_desc,
   output logic [AXI_MAX_ADDR_WIDTH-1:0] o_next_addr
);

   localparam logic [AXI_MAX_ADDR_WIDTH:0]   c_span = (AXI_MAX_ADDR_WIDTH+1)'(1) << ADDRESS_WIDTH;
   localparam logic [AXI_MAX_ADDR_WIDTH-1:0] c_addr_mask = AXI_MAX_ADDR_WIDTH'(c_span - 1'b1);

   logic [AXI_MAX_ADDR_WIDTH-1:0] w_step;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_incr;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_wrap_bytes;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_wrap_mask;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_wrap;
   logic                          w_wrap_ok;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_raw;

   assign w_step = AXI_MAX_ADDR_WIDTH'(1) << i_desc.size;
   assign w_incr = i_desc.addr + w_step;

   // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
   // The offset within the window advances; the window base stays put.
   assign w_wrap_bytes = (AXI_MAX_ADDR_WIDTH'(i_desc.len) + AXI_MAX_ADDR_WIDTH'(1)) << i_desc.size;
   assign w_wrap_mask  = w_wrap_bytes - AXI_MAX_ADDR_WIDTH'(1);
   assign w_wrap       = (i_desc.addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);

   // Only 2/4/8/16-beat wraps are legal; anything else degrades to INCR.
   assign w_wrap_ok = (i_desc.len == 8'd1) || (i_desc.len == 8'd3) ||
                      (i_desc.len == 8'd7) || (i_desc.len == 8'd15);

   always_comb begin
      w_raw = w_incr;
      case (i_desc.burst)
         AXI_BURST_FIXED: w_raw = i_desc.addr;
         AXI_BURST_INCR:  w_raw = w_incr;
         AXI_BURST_WRAP:  w_raw = w_wrap_ok ? w_wrap : w_incr;
         default:         w_raw = w_incr;
      endcase
   end

   assign o_next_addr = w_raw & c_addr_mask;

endmodule : axi_burst_addr_gen
`default_nettype wire

// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module  : axi_slave_ram
// Purpose : Read-only AXI4 memory slave. Accepts one read burst at a time
//           and returns beats from a RAM whose word i holds the value i.
// Ports   : aclk, aresetn          - clock, async active-low reset
//           araddr/arlen/arsize/arburst/arvalid/arready - AR channel
//           rdata/rresp/rlast/rvalid/rready            - R channel
// Revision: 1.0 - initial release
// ============================================================================
module axi_slave_ram
   import axi_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [ADDRESS_WIDTH-1:0] araddr,
   input  logic [7:0]               arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready
);

   localparam int c_bytes = DATA_WIDTH / 8;
   localparam int c_lsb   = $clog2(c_bytes);
   localparam int c_idx_w = ADDRESS_WIDTH - c_lsb;
   localparam int c_words = 1 << c_idx_w;

   rd_state_t                     r_state;
   rd_state_t                     w_state_nxt;
   axi_ar_desc_t                  r_desc;
   axi_ar_desc_t                  w_desc_nxt;
   logic [7:0]                    r_cnt;
   logic [7:0]                    w_cnt_nxt;
   logic                          r_arready;
   logic                          w_arready_nxt;
   logic                          r_rvalid;
   logic                          w_rvalid_nxt;
   logic                          r_rlast;
   logic                          w_rlast_nxt;
   logic [DATA_WIDTH-1:0]         r_rdata;
   logic [1:0]                    r_rresp;

   // Beat to load into the R registers this cycle (first beat or next beat).
   logic                          w_load;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_beat_addr;
   logic [2:0]                    w_beat_size;
   logic                          w_beat_err;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_word_idx;
   logic [DATA_WIDTH-1:0]         w_mem_word;
   logic                          w_unused_idx_bits;
   logic [AXI_MAX_ADDR_WIDTH-1:0] w_gen_next;

   logic [DATA_WIDTH-1:0]         r_mem [c_words];

   axi_burst_addr_gen #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_addr_gen (
      .i_desc      (r_desc),
      .o_next_addr (w_gen_next)
   );

   // Preloaded pattern; there is no write port so contents only change on
   // reset, which reloads them.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < c_words; i++) begin
            r_mem[i] <= DATA_WIDTH'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_desc_nxt    = r_desc;
      w_cnt_nxt     = r_cnt;
      w_arready_nxt = r_arready;
      w_rvalid_nxt  = r_rvalid;
      w_rlast_nxt   = r_rlast;
      w_load        = 1'b0;
      w_beat_addr   = r_desc.addr;
      w_beat_size   = r_desc.size;

      case (r_state)
         S_IDLE: begin
            // arready is registered low during reset and rises one edge later.
            w_arready_nxt = 1'b1;
            if (arvalid && r_arready) begin
               w_desc_nxt.addr  = AXI_MAX_ADDR_WIDTH'(araddr);
               w_desc_nxt.len   = arlen;
               w_desc_nxt.size  = arsize;
               w_desc_nxt.burst = arburst;
               w_cnt_nxt        = 8'd0;
               w_state_nxt      = S_BURST;
               w_arready_nxt    = 1'b0;
               w_rvalid_nxt     = 1'b1;
               w_rlast_nxt      = (arlen == 8'd0);
               w_load           = 1'b1;
               w_beat_addr      = AXI_MAX_ADDR_WIDTH'(araddr);
               w_beat_size      = arsize;
            end
         end

         S_BURST: begin
            w_arready_nxt = 1'b0;
            if (rready) begin
               if (r_rlast) begin
                  w_state_nxt   = S_IDLE;
                  w_rvalid_nxt  = 1'b0;
                  w_rlast_nxt   = 1'b0;
                  w_arready_nxt = 1'b1;
               end else begin
                  w_desc_nxt.addr = w_gen_next;
                  w_cnt_nxt       = r_cnt + 8'd1;
                  w_rlast_nxt     = ((r_cnt + 8'd1) == r_desc.len);
                  w_load          = 1'b1;
                  w_beat_addr     = w_gen_next;
               end
            end
         end

         default: begin
            w_state_nxt   = S_IDLE;
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
            w_arready_nxt = 1'b0;
         end
      endcase
   end

   // Transfers wider than the bus are answered with SLVERR and zero data,
   // but the beat count is still honoured.
   assign w_beat_err        = (w_beat_size > 3'(c_lsb));
   assign w_word_idx        = w_beat_addr >> c_lsb;
   assign w_mem_word        = r_mem[w_word_idx[c_idx_w-1:0]];
   assign w_unused_idx_bits = |w_word_idx[AXI_MAX_ADDR_WIDTH-1:c_idx_w];

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_desc    <= '0;
         r_cnt     <= 8'd0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= AXI_RESP_OKAY;
      end else begin
         r_state   <= w_state_nxt;
         r_desc    <= w_desc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_arready <= w_arready_nxt;
         r_rvalid  <= w_rvalid_nxt;
         r_rlast   <= w_rlast_nxt;
         // Data/resp only change when a new beat is loaded, so they hold
         // stable while the master stalls.
         if (w_load) begin
            r_rdata <= w_beat_err ? '0 : w_mem_word;
            r_rresp <= w_beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
      end
   end

   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rlast;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

endmodule : axi_slave_ram
`default_nettype wire

// File: tb/tb_axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_slave_ram
// Purpose : Self-checking bench for axi_slave_ram. Expected beats come from
//           an arithmetic model of the AXI address rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_slave_ram;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          aclk;
   logic          aresetn;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   int vectors     = 0;
   int miscompares = 0;

   axi_slave_ram #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Byte address of beat k, straight from the burst-type rules.
   function automatic int model_addr(int addr, int len, int size, int burst, int k);
      int step;
      int span;
      int w;
      int lower;
      int a;
      step = 1 << size;
      span = 1 << AW;
      if (burst == 0) begin
         a = addr;
      end else if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         w     = (len + 1) * step;
         lower = (addr / w) * w;
         a     = lower + ((addr - lower + k * step) % w);
      end else begin
         a = addr + k * step;
      end
      return a % span;
   endfunction

   task automatic run_burst(input int addr, input int len, input int size, input int burst,
                            input int rready_pct, input int init_stall, input bit hold_arvalid);
      logic [31:0] exp_data[$];
      logic [1:0]  exp_resp;
      bit          err;
      bit          accepted;
      bit          rdy_at_edge;
      int          k;
      int          cyc;
      err      = (size > 2);
      exp_resp = err ? 2'b10 : 2'b00;
      for (int b = 0; b <= len; b++) begin
         exp_data.push_back(err ? 32'd0 : 32'(model_addr(addr, len, size, burst, b) / 4));
      end
      araddr  = AW'(addr);
      arlen   = 8'(len);
      arsize  = 3'(size);
      arburst = 2'(burst);
      arvalid = 1'b1;
      rready  = 1'b0;
      accepted = 1'b0;
      for (int c = 0; c < 20 && !accepted; c++) begin
         rdy_at_edge = arready;
         @(posedge aclk); #1;
         if (rdy_at_edge) accepted = 1'b1;
      end
      vectors++;
      if (!accepted) begin
         $display("FAIL ar_accept: arready never high (got 0, need 1) addr=%0h", addr);
         miscompares++;
         arvalid = 1'b0;
         return;
      end
      if (!hold_arvalid) arvalid = 1'b0;
      k   = 0;
      cyc = 0;
      while (k <= len && cyc < 4000) begin
         rready = (cyc < init_stall) ? 1'b0 : ($urandom_range(99) < rready_pct);
         vectors++;
         if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== exp_data[k] ||
             rresp !== exp_resp || rlast !== (k == len)) begin
            $display("FAIL beat%0d addr=%0h len=%0d size=%0d burst=%0d: got rvalid=%0b arready=%0b rdata=%0d rresp=%0d rlast=%0b, need rvalid=1 arready=0 rdata=%0d rresp=%0d rlast=%0b",
                     k, addr, len, size, burst, rvalid, arready, rdata, rresp, rlast,
                     exp_data[k], exp_resp, (k == len));
            miscompares++;
         end
         @(posedge aclk); #1;
         if (rready) k++;
         cyc++;
      end
      arvalid = 1'b0;
      rready  = 1'b0;
      vectors++;
      if (k <= len) begin
         $display("FAIL burst_timeout: got %0d beats, need %0d", k, len + 1);
         miscompares++;
      end
      vectors++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         $display("FAIL burst_end: got rvalid=%0b arready=%0b, need rvalid=0 arready=1", rvalid, arready);
         miscompares++;
      end
   endtask

   task automatic test_reset();
      araddr  = '0;
      arlen   = '0;
      arsize  = '0;
      arburst = '0;
      arvalid = 1'b0;
      rready  = 1'b0;
      aresetn = 1'b1;
      #1 aresetn = 1'b0;
      #1;
      vectors++;
      if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rdata !== '0) begin
         $display("FAIL reset_values: got arready=%0b rvalid=%0b rlast=%0b rresp=%0d rdata=%0d, need all 0",
                  arready, rvalid, rlast, rresp, rdata);
         miscompares++;
      end
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      vectors++;
      if (arready !== 1'b0) begin
         $display("FAIL reset_hold: got arready=%0b, need 0 before first edge", arready);
         miscompares++;
      end
      @(posedge aclk); #1;
      vectors++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         $display("FAIL reset_release: got arready=%0b rvalid=%0b, need arready=1 rvalid=0", arready, rvalid);
         miscompares++;
      end
   endtask

   task automatic test_incr();
      run_burst(32'h00, 5, 2, 1, 100, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_burst(32'h00, 5, 2, 1, 100, 20, 1'b1);
   endtask

   task automatic test_top_wrap();
      run_burst(32'hF8, 3, 2, 1, 100, 0, 1'b0);
   endtask

   task automatic test_wrap_fixed();
      run_burst(32'h34, 3, 2, 2, 100, 0, 1'b0);
      run_burst(32'h10, 2, 2, 0, 100, 0, 1'b0);
      run_burst(32'h34, 2, 2, 2, 70, 0, 1'b0);
      run_burst(32'h40, 3, 2, 3, 70, 0, 1'b0);
   endtask

   task automatic test_error();
      run_burst(32'h00, 1, 3, 1, 100, 0, 1'b0);
      run_burst(32'h20, 1, 2, 1, 100, 0, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      araddr  = 8'h00;
      arlen   = 8'd7;
      arsize  = 3'd2;
      arburst = 2'd1;
      arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      rready  = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'd2) begin
         $display("FAIL mid_third_beat: got rvalid=%0b rdata=%0d, need rvalid=1 rdata=2", rvalid, rdata);
         miscompares++;
      end
      #2 aresetn = 1'b0;
      #1;
      vectors++;
      if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0 || rdata !== '0) begin
         $display("FAIL mid_reset_abort: got rvalid=%0b arready=%0b rlast=%0b rdata=%0d, need all 0",
                  rvalid, arready, rlast, rdata);
         miscompares++;
      end
      rready = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      vectors++;
      if (rvalid !== 1'b0) begin
         $display("FAIL mid_reset_quiet: got rvalid=%0b, need 0", rvalid);
         miscompares++;
      end
      @(posedge aclk); #1;
      vectors++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         $display("FAIL mid_reset_release: got arready=%0b rvalid=%0b, need arready=1 rvalid=0", arready, rvalid);
         miscompares++;
      end
      run_burst(32'h08, 0, 2, 1, 100, 0, 1'b0);
   endtask

   task automatic test_random();
      int len;
      int sel;
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(3));
         case (sel)
            0:       len = (2 << $urandom_range(3)) - 1;
            1:       len = int'($urandom_range(20));
            2:       len = int'($urandom_range(255));
            default: len = 0;
         endcase
         run_burst(int'($urandom_range(255)), len, int'($urandom_range(4)), int'($urandom_range(3)),
                   int'($urandom_range(100, 30)), 0, 1'($urandom_range(1)));
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++) begin
         run_burst(int'($urandom_range(255)), int'($urandom_range(7)), 2, 1, 100, 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_stall();
      test_top_wrap();
      test_wrap_fixed();
      test_error();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_axi_slave_ram
`default_nettype wire
